// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side (IF + DM) and memory-side bundles for the shared memory port.
// The arbiter takes the slave view of the pipeline bundle and the master view of the memory bundle.
interface mem_port_req_if #(
    parameter int XLEN = 32
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_flush;
    logic            if_valid;
    logic [XLEN-1:0] if_rdata;
    logic            dm_req;
    logic            dm_we;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic [3:0]      dm_be;
    logic            dm_valid;
    logic [XLEN-1:0] dm_rdata;
    logic            stall_if;
    logic            stall_mem;

    modport master (
        output if_req, if_addr, if_flush,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  if_valid, if_rdata, dm_valid, dm_rdata, stall_if, stall_mem
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output if_valid, if_rdata, dm_valid, dm_rdata, stall_if, stall_mem
    );
endinterface

interface mem_port_bus_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// IF/DM arbiter for one single-ported memory, one transaction in flight; request->mem_req 1 cycle, 4-cycle issue period.
// Requests are held by the pipeline (stall_if/stall_mem) while waiting; mem_req is held until mem_gnt.
module mem_port_arbiter #(
    parameter int XLEN          = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_port_req_if.slave  pipe_io,
    mem_port_bus_if.master mem_io
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] MAX_STREAK = 4'(MAX_DM_STREAK);

    state_t          state_q,     state_d;
    logic            owner_dm_q,  owner_dm_d;
    logic            discard_q,   discard_d;
    logic [3:0]      streak_q,    streak_d;
    logic            mem_req_q,   mem_req_d;
    logic            mem_we_q,    mem_we_d;
    logic [XLEN-1:0] mem_addr_q,  mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_be_q,    mem_be_d;
    logic            if_valid_q,  if_valid_d;
    logic            dm_valid_q,  dm_valid_d;
    logic [XLEN-1:0] if_rdata_q,  if_rdata_d;
    logic [XLEN-1:0] dm_rdata_q,  dm_rdata_d;

    logic if_eligible;
    logic flush_hit;
    logic dm_grant;
    logic if_grant;

    // A fetch being cancelled in the same cycle never wins arbitration.
    assign if_eligible = pipe_io.if_req & ~pipe_io.if_flush;
    assign flush_hit   = pipe_io.if_flush & ~owner_dm_q &
                         ((state_q == S_REQ) || (state_q == S_RESP));

    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        discard_d   = discard_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        dm_grant    = 1'b0;
        if_grant    = 1'b0;

        case (state_q)
            S_IDLE: begin
                discard_d = 1'b0;
                if (pipe_io.dm_req && (!if_eligible || (streak_q < MAX_STREAK))) begin
                    dm_grant = 1'b1;
                end else if (if_eligible) begin
                    if_grant = 1'b1;
                end
                if (dm_grant || if_grant) begin
                    state_d     = S_REQ;
                    owner_dm_d  = dm_grant;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_grant & pipe_io.dm_we;
                    mem_addr_d  = dm_grant ? pipe_io.dm_addr  : pipe_io.if_addr;
                    mem_wdata_d = dm_grant ? pipe_io.dm_wdata : '0;
                    mem_be_d    = dm_grant ? pipe_io.dm_be    : 4'hF;
                end
            end
            S_REQ: begin
                if (flush_hit) begin
                    discard_d = 1'b1;
                end
                if (mem_io.mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (flush_hit) begin
                    discard_d = 1'b1;
                end
                if (mem_io.mem_rvalid) begin
                    state_d = S_DONE;
                    if (owner_dm_q) begin
                        dm_valid_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_io.mem_rdata;
                        end
                    end else if (!(discard_q || flush_hit)) begin
                        // A cancelled fetch still drains on the memory side but is never delivered.
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_io.mem_rdata;
                    end
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                discard_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!pipe_io.if_req) begin
            streak_d = '0;
        end else if (if_grant) begin
            streak_d = '0;
        end else if (dm_grant && (streak_q < MAX_STREAK)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_dm_q  <= 1'b0;
            discard_q   <= 1'b0;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            discard_q   <= discard_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_io.mem_req   = mem_req_q;
    assign mem_io.mem_we    = mem_we_q;
    assign mem_io.mem_addr  = mem_addr_q;
    assign mem_io.mem_wdata = mem_wdata_q;
    assign mem_io.mem_be    = mem_be_q;

    assign pipe_io.if_valid  = if_valid_q;
    assign pipe_io.if_rdata  = if_rdata_q;
    assign pipe_io.dm_valid  = dm_valid_q;
    assign pipe_io.dm_rdata  = dm_rdata_q;
    assign pipe_io.stall_if  = pipe_io.if_req & ~if_valid_q & ~pipe_io.if_flush;
    assign pipe_io.stall_mem = pipe_io.dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-response memory model and a grant gate.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic gnt_en = 1'b1;
    logic            rvalid_q;
    logic [XLEN-1:0] rdata_q;

    int checks   = 0;
    int failures = 0;

    mem_port_req_if #(.XLEN(XLEN)) pipe ();
    mem_port_bus_if #(.XLEN(XLEN)) mem ();

    mem_port_arbiter #(.XLEN(XLEN), .MAX_DM_STREAK(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .pipe_io (pipe),
        .mem_io  (mem)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
        case (a)
            32'h0000_0100: mem_word = 32'h0050_0093;
            32'h0000_0200: mem_word = 32'h00a0_0113;
            32'h0000_2000: mem_word = 32'hCAFE_F00D;
            default:       mem_word = a ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    // Memory: accepts whenever enabled, answers exactly one cycle after the grant.
    assign mem.mem_gnt    = mem.mem_req & gnt_en;
    assign mem.mem_rvalid = rvalid_q;
    assign mem.mem_rdata  = rdata_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= mem.mem_req & mem.mem_gnt;
            rdata_q  <= (mem.mem_req & mem.mem_gnt) ? mem_word(mem.mem_addr) : '0;
        end
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pipe.if_req   = 1'b0;
        pipe.if_addr  = '0;
        pipe.if_flush = 1'b0;
        pipe.dm_req   = 1'b0;
        pipe.dm_we    = 1'b0;
        pipe.dm_addr  = '0;
        pipe.dm_wdata = '0;
        pipe.dm_be    = 4'h0;

        // Reset state
        nx();
        chk("rst_mem_req",  32'(mem.mem_req), 32'd0);
        chk("rst_mem_addr", mem.mem_addr, 32'd0);
        chk("rst_if_valid", 32'(pipe.if_valid), 32'd0);
        chk("rst_dm_valid", 32'(pipe.dm_valid), 32'd0);
        chk("rst_if_rdata", pipe.if_rdata, 32'd0);
        chk("rst_dm_rdata", pipe.dm_rdata, 32'd0);
        chk("rst_stall_if", 32'(pipe.stall_if), 32'd0);
        rst = 1'b0;
        nx();

        // 1. Single fetch
        pipe.if_req = 1'b1; pipe.if_addr = 32'h100;
        #1;
        chk("t1_c0_stall_if", 32'(pipe.stall_if), 32'd1);
        chk("t1_c0_mem_req",  32'(mem.mem_req), 32'd0);
        nx();
        chk("t1_c1_mem_req",  32'(mem.mem_req), 32'd1);
        chk("t1_c1_mem_addr", mem.mem_addr, 32'h100);
        chk("t1_c1_mem_be",   32'(mem.mem_be), 32'hF);
        chk("t1_c1_mem_we",   32'(mem.mem_we), 32'd0);
        chk("t1_c1_stall_if", 32'(pipe.stall_if), 32'd1);
        nx();
        chk("t1_c2_mem_req",  32'(mem.mem_req), 32'd0);
        chk("t1_c2_if_valid", 32'(pipe.if_valid), 32'd0);
        chk("t1_c2_stall_if", 32'(pipe.stall_if), 32'd1);
        nx();
        chk("t1_c3_if_valid", 32'(pipe.if_valid), 32'd1);
        chk("t1_c3_if_rdata", pipe.if_rdata, 32'h0050_0093);
        chk("t1_c3_stall_if", 32'(pipe.stall_if), 32'd0);
        pipe.if_req = 1'b0;
        nx();
        chk("t1_c4_if_valid", 32'(pipe.if_valid), 32'd0);

        // 2. Collision: DM load first, IF after DM's DONE
        pipe.if_req = 1'b1; pipe.if_addr = 32'h108;
        pipe.dm_req = 1'b1; pipe.dm_we = 1'b0; pipe.dm_addr = 32'h2000; pipe.dm_be = 4'hF;
        nx();
        chk("t2_dm_addr",      mem.mem_addr, 32'h2000);
        chk("t2_dm_we",        32'(mem.mem_we), 32'd0);
        nx(); nx();
        chk("t2_dm_valid",     32'(pipe.dm_valid), 32'd1);
        chk("t2_dm_rdata",     pipe.dm_rdata, 32'hCAFE_F00D);
        chk("t2_if_wait",      32'(pipe.if_valid), 32'd0);
        chk("t2_stall_if",     32'(pipe.stall_if), 32'd1);
        pipe.dm_req = 1'b0;
        nx();
        chk("t2_idle_mem_req", 32'(mem.mem_req), 32'd0);
        nx();
        chk("t2_if_addr",      mem.mem_addr, 32'h108);
        chk("t2_if_be",        32'(mem.mem_be), 32'hF);
        nx(); nx();
        chk("t2_if_valid",     32'(pipe.if_valid), 32'd1);
        chk("t2_if_rdata",     pipe.if_rdata, 32'hA5A5_A4AD);
        pipe.if_req = 1'b0;
        nx();

        // 3. Starvation guard: DM,DM,DM,DM,IF,DM
        pipe.if_req = 1'b1; pipe.if_addr = 32'h10C;
        pipe.dm_req = 1'b1; pipe.dm_we = 1'b0; pipe.dm_addr = 32'h3000; pipe.dm_be = 4'hF;
        for (int k = 0; k < 6; k++) begin
            nx();
            chk($sformatf("t3_g%0d_mem_req", k), 32'(mem.mem_req), 32'd1);
            chk($sformatf("t3_g%0d_addr", k), mem.mem_addr, (k == 4) ? 32'h10C : 32'h3000);
            if (k == 4) chk("t3_stall_mem", 32'(pipe.stall_mem), 32'd1);
            nx(); nx();
            if (k == 4) begin
                chk("t3_if_valid", 32'(pipe.if_valid), 32'd1);
                chk("t3_if_rdata", pipe.if_rdata, 32'hA5A5_A4A9);
                pipe.if_req = 1'b0;
            end else begin
                chk($sformatf("t3_g%0d_dm_valid", k), 32'(pipe.dm_valid), 32'd1);
                if (k == 5) pipe.dm_req = 1'b0;
            end
            nx();
        end
        chk("t3_dm_rdata", pipe.dm_rdata, 32'hA5A5_95A5);

        // 4. Store leaves dm_rdata unchanged
        pipe.dm_req = 1'b1; pipe.dm_we = 1'b1; pipe.dm_addr = 32'h2004;
        pipe.dm_wdata = 32'hDEAD_BEEF; pipe.dm_be = 4'b0011;
        nx();
        chk("t4_mem_we",    32'(mem.mem_we), 32'd1);
        chk("t4_mem_addr",  mem.mem_addr, 32'h2004);
        chk("t4_mem_wdata", mem.mem_wdata, 32'hDEAD_BEEF);
        chk("t4_mem_be",    32'(mem.mem_be), 32'h3);
        nx(); nx();
        chk("t4_dm_valid",  32'(pipe.dm_valid), 32'd1);
        chk("t4_dm_rdata",  pipe.dm_rdata, 32'hA5A5_95A5);
        pipe.dm_req = 1'b0; pipe.dm_we = 1'b0;
        nx();

        // 5. Flush during RESP of 0x104, then 0x200 served normally
        pipe.if_req = 1'b1; pipe.if_addr = 32'h104;
        nx();
        chk("t5_mem_addr", mem.mem_addr, 32'h104);
        nx();
        pipe.if_flush = 1'b1;
        #1;
        chk("t5_stall_flush", 32'(pipe.stall_if), 32'd0);
        nx();
        chk("t5_no_if_valid", 32'(pipe.if_valid), 32'd0);
        chk("t5_if_rdata",    pipe.if_rdata, 32'hA5A5_A4A9);
        pipe.if_flush = 1'b0; pipe.if_addr = 32'h200;
        nx();
        nx();
        chk("t5_next_addr", mem.mem_addr, 32'h200);
        nx(); nx();
        chk("t5_next_valid", 32'(pipe.if_valid), 32'd1);
        chk("t5_next_rdata", pipe.if_rdata, 32'h00a0_0113);
        pipe.if_req = 1'b0;
        nx();

        // 5b. Flush while still in REQ: mem_req held, result dropped later
        pipe.if_req = 1'b1; pipe.if_addr = 32'h204; gnt_en = 1'b0;
        nx();
        pipe.if_flush = 1'b1;
        nx();
        chk("t5b_req_held", 32'(mem.mem_req), 32'd1);
        pipe.if_flush = 1'b0; pipe.if_req = 1'b0; gnt_en = 1'b1;
        nx();
        chk("t5b_granted", 32'(mem.mem_req), 32'd0);
        nx();
        chk("t5b_no_if_valid", 32'(pipe.if_valid), 32'd0);
        chk("t5b_if_rdata",    pipe.if_rdata, 32'h00a0_0113);
        nx();

        // 6. Reset in REQ with grant withheld
        gnt_en = 1'b0;
        pipe.dm_req = 1'b1; pipe.dm_we = 1'b0; pipe.dm_addr = 32'h2008; pipe.dm_be = 4'hF;
        nx();
        chk("t6_req_before", 32'(mem.mem_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_mem_req", 32'(mem.mem_req), 32'd0);
        chk("t6_rst_state",   32'(dut.state_q), 32'd0);
        chk("t6_rst_if_rdata", pipe.if_rdata, 32'd0);
        chk("t6_rst_dm_rdata", pipe.dm_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0; gnt_en = 1'b1;
        nx();
        chk("t6_reissue_req",  32'(mem.mem_req), 32'd1);
        chk("t6_reissue_addr", mem.mem_addr, 32'h2008);
        nx(); nx();
        chk("t6_dm_valid", 32'(pipe.dm_valid), 32'd1);
        chk("t6_dm_rdata", pipe.dm_rdata, 32'hA5A5_85AD);
        pipe.dm_req = 1'b0;
        nx();
        chk("t6_dm_valid_off", 32'(pipe.dm_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch stage (IF) and the data-memory stage (DM) of the 5-stage pipeline. Supports one outstanding transaction, chosen by priority with a starvation guard. Drives stall requests into the hazard logic while a requester waits. Handles fetch cancellation on a taken branch (PCSrcE).

Parameters:
XLEN, 32, address/data width
MAX_DM_STREAK, 4, max consecutive DM grants while if_req is pending before IF is forced; range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch request, held until if_valid or flush
if_addr  in  XLEN  fetch address
if_flush  in  1  cancel fetch (PCSrcE)
if_valid  out  1  one-cycle fetch completion pulse
if_rdata  out  XLEN  fetched instruction
dm_req  in  1  data request, held until dm_valid
dm_we  in  1  1 = store
dm_addr  in  XLEN  data address
dm_wdata  in  XLEN  store data
dm_be  in  4  byte enables
dm_valid  out  1  one-cycle data completion pulse (loads and stores)
dm_rdata  out  XLEN  load data
mem_req  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  XLEN  memory address
mem_wdata  out  XLEN  memory write data
mem_be  out  4  memory byte enables (4'hF for fetch)
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  response/ack, exactly one per granted request, no earlier than the cycle after gnt
mem_rdata  in  XLEN  read data, valid with mem_rvalid
stall_if  out  1  = if_req & ~if_valid & ~if_flush (combinational)
stall_mem  out  1  = dm_req & ~dm_valid (combinational)

Behaviour:
- Reset (async, any state): state=IDLE; all registered outputs=0, including if_rdata, dm_rdata, mem_*; streak counter=0; discard flag=0. An in-flight transaction is abandoned; the memory is reset by the same rst.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE behaviour:
  - If either request is pending, latch owner, addr, we, wdata, be and go to REQ.
  - Owner=DM if dm_req and (no if_req or streak<MAX_DM_STREAK); otherwise IF.
  - An IF request with if_flush high in the same cycle is not arbitrated.
- REQ: mem_req=1 with latched fields, held stable until mem_gnt. On gnt, go to RESP the next cycle. mem_req is never withdrawn before gnt, even on flush.
- RESP: wait for mem_rvalid.
  - Capture mem_rdata into if_rdata (owner IF) or dm_rdata (owner DM, read only). Store completions leave dm_rdata unchanged.
  - Go to DONE.
- DONE: pulse if_valid or dm_valid for exactly one cycle; no arbitration in this cycle; next state IDLE.
- Latency: request seen in IDLE at cycle 0 → mem_req at cycle 1. With gnt at cycle 1 and rvalid at cycle 2, the valid pulse is at cycle 3. Back-to-back issue period is 4 cycles.
- Flush:
  - if_flush while owner=IF in REQ or RESP sets the discard flag.
  - The transaction still completes on the memory side, but if_valid is suppressed and if_rdata is not updated.
  - The flag clears on entering IDLE.
  - if_flush while owner=DM has no effect on the transaction.
- Starvation counter:
  - Increments on each DM grant made while if_req is high; saturates at MAX_DM_STREAK.
  - Clears on an IF grant, or in any cycle where if_req is low.
- Simultaneous dm_req and if_req with streak<MAX_DM_STREAK: DM wins.
- Requests arriving in REQ, RESP or DONE wait; inputs from non-owners are ignored.
- mem_be=4'hF and mem_we=0 for fetches.

Test Plan:
1. Single fetch: if_req=1, if_addr=0x100. Memory gnt immediately, rvalid next cycle, rdata=0x00500093. Required: mem_req at cycle 1 with addr 0x100, be=F; if_valid at cycle 3 with if_rdata=0x00500093; stall_if high in cycles 0–2.
2. Collision: if_req and dm_req (load 0x2000) both raised at cycle 0. Required: DM issued first; IF issued in the IDLE following DM's DONE; dm_valid precedes if_valid.
3. Starvation, MAX_DM_STREAK=4: dm_req held high continuously with if_req high. Required: grant order DM,DM,DM,DM,IF,DM…
4. Store: dm_we=1, addr=0x2004, wdata=0xDEADBEEF, be=4'b0011. Required: mem_we=1 with those values; dm_valid pulses; dm_rdata keeps its previous value.
5. Flush: if_flush pulsed during RESP of fetch 0x104. Required: no if_valid, if_rdata unchanged; the next if_req for 0x200 is served normally.
6. Reset in REQ with mem_gnt held low. Required: immediately mem_req=0 and state IDLE; a new dm_req issues normally after rst drops.
